// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit sampling, stop check.
// Drives an external SIPO through sample_bit/shift.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic baud_tick,
  output logic sample_bit,
  output logic shift,
  output logic rx_done,
  output logic frame_err,
  output logic busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_END = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;

  logic sync1;
  logic rx_s;

  logic sample_q, sample_d;
  logic shift_q, shift_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic tick_half;
  logic tick_last;

  assign tick_half = (tick_q == HALF_END);
  assign tick_last = (tick_q == BIT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      rx_s     <= 1'b1;
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1    <= rx;
      rx_s     <= sync1;
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Pulses are registered, so each lands in the cycle after its decision tick.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    sample_d = sample_q;
    shift_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
            bit_d   = '0;
          end
        end
        START: begin
          if (tick_half) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_last) begin
            sample_d = rx_s;
            shift_d  = 1'b1;
            bit_d    = bit_q + 1'b1;
            tick_d   = '0;
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_last) begin
            tick_d = '0;
            if (rx_s) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = BREAK;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign sample_bit = sample_q;
  assign shift      = shift_q;
  assign rx_done    = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != IDLE);

endmodule
